boot_stream_loader: RTL and testbench
=====================================

// Module: boot_stream_loader
// PURPOSE
//  Write-side counterpart of the boot ROM read path: accepts a byte stream (from the UART RX
//  path during boot), assembles little-endian 32-bit words and writes them into a word-addressed
//  RAM port. Frame = 4-byte LE payload length in bytes, then payload (+ optional checksum byte).
//  Sits between the boot UART receiver and the instruction/data RAM write port.
// PARAMETERS
//  ADDR_W     12  RAM word-address width; max payload = 4*2^ADDR_W bytes
//  BASE_ADDR  0   word address of the first payload word
// PORTS
//  i_clk       in   1       clock
//  i_rst       in   1       asynchronous, active-high reset
//  i_data      in   8       stream byte
//  i_valid     in   1       i_data valid; byte accepted when i_valid & o_ready
//  o_ready     out  1       loader can accept a byte
//  i_restart   in   1       one-cycle pulse: DONE/ERR -> HDR, clears o_done/o_err
//  o_mem_addr  out  ADDR_W  RAM word address
//  o_mem_data  out  32      RAM write data (byte 0 of word in [7:0])
//  o_mem_we    out  4       per-byte write enables, asserted one cycle per word
//  o_busy      out  1       frame in progress (HDR with >=1 byte taken, DATA, CSUM)
//  o_done      out  1       frame complete (sticky until i_restart/reset)
//  o_err       out  1       length overflow or checksum mismatch (sticky)
// BEHAVIOUR
//  - Reset: state HDR, o_ready=1, o_mem_we=0, o_mem_addr=BASE_ADDR, o_mem_data=0, o_busy=0,
//    o_done=0, o_err=0, counters/checksum zero. Reset mid-frame aborts; no write pulse issued.
//  - States: HDR -> DATA -> [CSUM] -> DONE; HDR -> ERR; any -> HDR on reset.
//  - HDR: collects 4 length bytes LSB first. On 4th byte: len==0 -> CSUM (macro on) else DONE;
//    len > 4*2^ADDR_W -> ERR; else DATA. Length is 32-bit unsigned; no wrap.
//  - DATA: o_ready=1 every cycle (no backpressure); bytes fill an assembly register, lane =
//    byte index mod 4. On the byte completing a word, or the final payload byte, the word moves
//    to the write register: next cycle o_mem_we = lanes received (4'b1111, or 0001/0011/0111
//    for a partial last word), o_mem_addr = BASE_ADDR + word index. we high exactly one cycle;
//    address advances after each pulse. Back-to-back bytes give a pulse every 4th cycle.
//  - Final payload byte: -> CSUM (macro on) or DONE. Last write pulse coincides with DONE entry.
//  - DONE/ERR: o_ready=0, input ignored, o_done (DONE) or o_err (ERR) held; o_busy=0.
//  - i_restart ignored outside DONE/ERR; in DONE/ERR, next cycle state=HDR, o_done=o_err=0,
//    address=BASE_ADDR, checksum=0.
//  - i_valid with o_ready=0 has no effect; i_data sampled only on handshake.
// CONFIGURATION
//  - LOADER_CHECKSUM_EN defined: after payload one extra byte C accepted in CSUM. Pass if
//    (sum of payload bytes + C) mod 256 == 0 -> DONE, o_done=1. Mismatch -> DONE with o_done=1
//    and o_err=1 (payload already written). Length bytes not in sum. len==0 still needs C.
//  - Not defined: no CSUM state; o_err only from length overflow; no checksum logic.
// TESTING
//  - len=8, payload 11..18 -> we=1111 @addr0 data 0x14131211, @addr1 0x18171615; o_done=1.
//  - len=5, payload AA BB CC DD EE -> @0 0xDDCCBBAA we=1111, @1 data[7:0]=EE we=0001; done.
//  - len=0 -> no write pulse, o_done=1 (with macro: after csum byte 00).
//  - ADDR_W=4, len=65 -> o_err=1, o_ready=0, no writes; i_restart -> o_ready=1, o_err=0.
//  - Macro on: len=2, 01 02, csum FD -> done, err=0; csum FE -> done=1, err=1; both @0 we=0011.
//  - Reset asserted after 6 payload bytes of len=8 -> outputs at reset values; new frame loads
//    from BASE_ADDR correctly.

Source files
------------

// File: rtl/boot_stream_loader.sv
// Boot stream loader: takes a length-prefixed byte stream and writes little-endian 32-bit words to a RAM port.
// Define LOADER_CHECKSUM_EN to add a trailing checksum byte that is checked after the payload.
module boot_stream_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_restart,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic [3:0]        o_mem_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned       RW       = ADDR_W + 3;
  localparam logic [32:0]       MAX_LEN  = 33'(64'd4 << ADDR_W);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_HDR, S_DATA, S_DONE, S_ERR} state_t;
`endif

  state_t            state_q, state_d;
  logic [1:0]        hdr_cnt_q;
  logic [23:0]       len_q;
  logic [RW-1:0]     rem_q;
  logic [1:0]        lane_q;
  logic [23:0]       asm_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        we_q;

  logic              accept;
  logic              last_byte;
  logic [31:0]       len_full;
  logic [31:0]       word_next;
  logic [3:0]        lane_mask;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
  logic              csum_err_q;
  logic [7:0]        csum_total;
  assign csum_total = sum_q + i_data;
`endif

  assign accept    = i_valid & o_ready;
  assign last_byte = (rem_q == RW'(1));
  assign len_full  = {i_data, len_q};

  always_comb begin
    word_next = {8'h00, asm_q};
    word_next[8*lane_q +: 8] = i_data;
    lane_mask = 4'b0001;
    case (lane_q)
      2'd0: lane_mask = 4'b0001;
      2'd1: lane_mask = 4'b0011;
      2'd2: lane_mask = 4'b0111;
      2'd3: lane_mask = 4'b1111;
      default: lane_mask = 4'b0001;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_HDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      S_HDR: begin
        o_ready = 1'b1;
        o_busy  = (hdr_cnt_q != 2'd0);
        if (accept && hdr_cnt_q == 2'd3) begin
          if (len_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, len_full} > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (accept && last_byte) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (accept) state_d = S_DONE;
      end
`endif
      S_DONE, S_ERR: begin
        if (i_restart) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hdr_cnt_q  <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      lane_q     <= '0;
      asm_q      <= '0;
      addr_q     <= BASE;
      data_q     <= '0;
      we_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
      csum_err_q <= 1'b0;
`endif
    end else begin
      we_q <= '0;
      // Address steps after each pulse so it names the pulsed word while we is high.
      if (we_q != 4'b0000) addr_q <= addr_q + ADDR_W'(1);
      case (state_q)
        S_HDR: begin
          if (accept) begin
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            len_q     <= {i_data, len_q[23:8]};
            if (hdr_cnt_q == 2'd3) begin
              rem_q  <= len_full[RW-1:0];
              lane_q <= '0;
              asm_q  <= '0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            rem_q  <= rem_q - RW'(1);
            lane_q <= lane_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q  <= csum_total;
`endif
            if (lane_q == 2'd3 || last_byte) begin
              data_q <= word_next;
              we_q   <= lane_mask;
              asm_q  <= '0;
            end else begin
              asm_q  <= word_next[23:0];
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept && csum_total != 8'h00) csum_err_q <= 1'b1;
        end
`endif
        S_DONE, S_ERR: begin
          if (i_restart) begin
            addr_q    <= BASE;
            hdr_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
            csum_err_q <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr = addr_q;
  assign o_mem_data = data_q;
  assign o_mem_we   = we_q;
  assign o_done     = (state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
  assign o_err      = (state_q == S_ERR) | csum_err_q;
`else
  assign o_err      = (state_q == S_ERR);
`endif

endmodule

// File: tb/tb_boot_stream_loader.sv
// Directed bench for boot_stream_loader (ADDR_W=4, so the largest legal payload is 64 bytes).
module tb_boot_stream_loader;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       i_restart;
  logic [3:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic [3:0] o_mem_we;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim[$];
  logic [3:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_we[$];

  always #5 clk = ~clk;

  boot_stream_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_restart(i_restart), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_we(o_mem_we), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always @(negedge clk) begin
    if (!i_rst && o_mem_we != 4'b0000) begin
      wq_addr.push_back(o_mem_addr);
      wq_data.push_back(o_mem_data);
      wq_we.push_back(o_mem_we);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qd(input int i);
    return (i < wq_data.size()) ? wq_data[i] : 'x;
  endfunction
  function automatic logic [31:0] qa(input int i);
    return (i < wq_addr.size()) ? {28'd0, wq_addr[i]} : 'x;
  endfunction
  function automatic logic [31:0] qw(input int i);
    return (i < wq_we.size()) ? {28'd0, wq_we[i]} : 'x;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rs);
    i_valid = 1'b1; i_data = b; i_restart = rs;
    @(posedge clk); #1;
    i_valid = 1'b0; i_restart = 1'b0;
  endtask

  // Back-to-back stream; optionally holds i_restart high on all but the last byte.
  task automatic send_stream(input bit hold_restart);
    for (int k = 0; k < stim.size(); k++) begin
      i_valid = 1'b1; i_data = stim[k];
      i_restart = hold_restart && (k < stim.size() - 1);
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_restart = 1'b0;
  endtask

  task automatic hdr(input logic [31:0] len);
    stim.delete();
    wq_addr.delete(); wq_data.delete(); wq_we.delete();
    for (int k = 0; k < 4; k++) stim.push_back(len[8*k +: 8]);
  endtask

  task automatic restart_pulse();
    i_restart = 1'b1;
    @(posedge clk); #1;
    i_restart = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    check({tag, "_we"},    {28'd0, o_mem_we}, 32'd0);
    check({tag, "_addr"},  {28'd0, o_mem_addr}, 32'd0);
    check({tag, "_data"},  o_mem_data, 32'd0);
    check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
    check({tag, "_done"},  {31'd0, o_done}, 32'd0);
    check({tag, "_err"},   {31'd0, o_err}, 32'd0);
  endtask

  task automatic frame_len5(input string tag);
    hdr(32'd5);
    send_byte(stim[0], 1'b0);
    check({tag, "_busy_hdr"}, {31'd0, o_busy}, 32'd1);
    void'(stim.pop_front());
    stim.push_back(8'hAA); stim.push_back(8'hBB); stim.push_back(8'hCC);
    stim.push_back(8'hDD); stim.push_back(8'hEE);
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h04);
`endif
    send_stream(1'b0);
    idle(2);
    check({tag, "_npulse"}, wq_data.size(), 32'd2);
    check({tag, "_a0"}, qa(0), 32'd0);
    check({tag, "_d0"}, qd(0), 32'hDDCCBBAA);
    check({tag, "_w0"}, qw(0), 32'hF);
    check({tag, "_a1"}, qa(1), 32'd1);
    check({tag, "_d1"}, qd(1) & 32'hFF, 32'hEE);
    check({tag, "_w1"}, qw(1), 32'h1);
    check({tag, "_done"}, {31'd0, o_done}, 32'd1);
    check({tag, "_err"},  {31'd0, o_err}, 32'd0);
    restart_pulse();
  endtask

  initial begin
    i_rst = 1'b1; i_data = 8'h00; i_valid = 1'b0; i_restart = 1'b0;
    idle(3);
    check_reset_vals("rst");
    i_rst = 1'b0;
    idle(1);

    // len=8, restart held during the stream must be ignored
    hdr(32'd8);
    for (int k = 0; k < 8; k++) stim.push_back(8'h11 + 8'(k));
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h5C);
`endif
    send_stream(1'b1);
    idle(2);
    check("l8_npulse", wq_data.size(), 32'd2);
    check("l8_a0", qa(0), 32'd0);
    check("l8_d0", qd(0), 32'h14131211);
    check("l8_w0", qw(0), 32'hF);
    check("l8_a1", qa(1), 32'd1);
    check("l8_d1", qd(1), 32'h18171615);
    check("l8_w1", qw(1), 32'hF);
    check("l8_done", {31'd0, o_done}, 32'd1);
    check("l8_err", {31'd0, o_err}, 32'd0);
    check("l8_ready", {31'd0, o_ready}, 32'd0);
    check("l8_busy", {31'd0, o_busy}, 32'd0);
    send_byte(8'h55, 1'b0);
    idle(1);
    check("l8_ignored", wq_data.size(), 32'd2);
    check("l8_still_done", {31'd0, o_done}, 32'd1);
    restart_pulse();
    check("l8_rs_done", {31'd0, o_done}, 32'd0);
    check("l8_rs_ready", {31'd0, o_ready}, 32'd1);
    check("l8_rs_addr", {28'd0, o_mem_addr}, 32'd0);

    frame_len5("l5");

    // len=0
    hdr(32'd0);
    send_stream(1'b0);
`ifdef LOADER_CHECKSUM_EN
    check("l0_wait_csum_done", {31'd0, o_done}, 32'd0);
    check("l0_wait_csum_busy", {31'd0, o_busy}, 32'd1);
    send_byte(8'h00, 1'b0);
`endif
    idle(2);
    check("l0_npulse", wq_data.size(), 32'd0);
    check("l0_done", {31'd0, o_done}, 32'd1);
    check("l0_err", {31'd0, o_err}, 32'd0);
    restart_pulse();

    // len=65 exceeds 64-byte capacity
    hdr(32'd65);
    send_stream(1'b0);
    send_byte(8'h01, 1'b0);
    idle(2);
    check("ovf_err", {31'd0, o_err}, 32'd1);
    check("ovf_done", {31'd0, o_done}, 32'd0);
    check("ovf_ready", {31'd0, o_ready}, 32'd0);
    check("ovf_busy", {31'd0, o_busy}, 32'd0);
    check("ovf_npulse", wq_data.size(), 32'd0);
    restart_pulse();
    check("ovf_rs_ready", {31'd0, o_ready}, 32'd1);
    check("ovf_rs_err", {31'd0, o_err}, 32'd0);

    // len=64 is exactly full capacity
    hdr(32'd64);
    for (int k = 0; k < 64; k++) stim.push_back(8'(k));
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h20);
`endif
    send_stream(1'b0);
    idle(2);
    check("l64_npulse", wq_data.size(), 32'd16);
    check("l64_d0", qd(0), 32'h03020100);
    check("l64_a15", qa(15), 32'd15);
    check("l64_d15", qd(15), 32'h3F3E3D3C);
    check("l64_w15", qw(15), 32'hF);
    check("l64_done", {31'd0, o_done}, 32'd1);
    check("l64_err", {31'd0, o_err}, 32'd0);
    restart_pulse();

`ifdef LOADER_CHECKSUM_EN
    hdr(32'd2);
    stim.push_back(8'h01); stim.push_back(8'h02); stim.push_back(8'hFD);
    send_stream(1'b0);
    idle(2);
    check("cs_ok_npulse", wq_data.size(), 32'd1);
    check("cs_ok_w0", qw(0), 32'h3);
    check("cs_ok_d0", qd(0) & 32'hFFFF, 32'h0201);
    check("cs_ok_done", {31'd0, o_done}, 32'd1);
    check("cs_ok_err", {31'd0, o_err}, 32'd0);
    restart_pulse();
    hdr(32'd2);
    stim.push_back(8'h01); stim.push_back(8'h02); stim.push_back(8'hFE);
    send_stream(1'b0);
    idle(2);
    check("cs_bad_w0", qw(0), 32'h3);
    check("cs_bad_a0", qa(0), 32'd0);
    check("cs_bad_done", {31'd0, o_done}, 32'd1);
    check("cs_bad_err", {31'd0, o_err}, 32'd1);
    restart_pulse();
    check("cs_rs_err", {31'd0, o_err}, 32'd0);
`endif

    // Reset after 6 payload bytes of an 8-byte frame
    hdr(32'd8);
    for (int k = 0; k < 6; k++) stim.push_back(8'h21 + 8'(k));
    send_stream(1'b0);
    idle(1);
    check("mid_npulse", wq_data.size(), 32'd1);
    i_rst = 1'b1;
    #2;
    check_reset_vals("mid_rst");
    idle(2);
    i_rst = 1'b0;
    idle(1);
    frame_len5("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
